seq_multiplier: RTL and testbench

Sequential unsigned shift-add multiplier, the inverse-operation partner of the team's sequential divider. It shares that divider's start/busy/valid handshake, operand widths and overflow flag convention. Divider results can be fed straight back through it for quotient×divisor checks. It sits beside the divider in the arithmetic datapath and needs one cycle per multiplier bit.

---
 rtl/seq_multiplier.sv | 112 +++++++++++
 tb/tb_seq_multiplier.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per CALC cycle.
// Optional early termination when no set multiplier bits remain: define MUL_EARLY_TERM_EN.
module seq_multiplier #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] pout,
    output logic             ovf,
    output logic             busy,
    output logic             valid
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   pout_q, pout_d;
    logic               ovf_q, ovf_d;

    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic               last_step;

    always_comb begin
        addend = r_q[0] ? m_q : '0;
        sum    = p_q + addend;
`ifdef MUL_EARLY_TERM_EN
        // Stop once the bits still to be shifted in are all zero.
        last_step = (cnt_q == LAST_CNT) || ((r_q >> 1) == '0);
`else
        last_step = (cnt_q == LAST_CNT);
`endif
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        r_d     = r_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        pout_d  = pout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = {{WIDTH{1'b0}}, a_in};
                    r_d     = b_in;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                p_d   = sum;
                m_d   = m_q << 1;
                r_d   = r_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    // Result registers capture the sum including this cycle's add.
                    pout_d  = sum[WIDTH-1:0];
                    ovf_d   = |sum[2*WIDTH-1:WIDTH];
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sclr) begin
            state_q <= StIdle;
            m_q     <= '0;
            r_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            r_q     <= r_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pout  = pout_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q == StCalc);
    assign valid = (state_q == StDone);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=10), full or early-termination build.
module tb_seq_multiplier;

    localparam int unsigned WIDTH = 10;

    logic             clk;
    logic             sclr;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] pout;
    logic             ovf;
    logic             busy;
    logic             valid;

    int n_cmp = 0;
    int n_err = 0;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .sclr (sclr),
        .start(start),
        .a_in (a_in),
        .b_in (b_in),
        .pout (pout),
        .ovf  (ovf),
        .busy (busy),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Counts remaining busy cycles from the current sample, then checks the valid pulse.
    task automatic wait_result(input string tag, input int exp_p, input int exp_ovf,
                               input int exp_busy, input int already);
        int cnt;
        cnt = already;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
        check({tag, " busy_cycles"}, cnt, exp_busy);
        check({tag, " valid"}, {31'd0, valid}, 1);
        check({tag, " pout"}, {22'd0, pout}, exp_p);
        check({tag, " ovf"}, {31'd0, ovf}, exp_ovf);
        step();
        check({tag, " valid_one_cycle"}, {31'd0, valid}, 0);
        check({tag, " pout_hold"}, {22'd0, pout}, exp_p);
    endtask

    task automatic run_op(input string tag, input int a, input int b, input int exp_p,
                          input int exp_ovf, input int exp_busy);
        start = 1'b1;
        a_in  = WIDTH'(a);
        b_in  = WIDTH'(b);
        step();
        start = 1'b0;
        wait_result(tag, exp_p, exp_ovf, exp_busy, 0);
    endtask

    initial begin
        int pulse_at;
        int rst_at;
        int vcount;

        sclr  = 1'b0;
        start = 1'b1;
        a_in  = 10'd3;
        b_in  = 10'd3;

        // Reset held for two edges with start asserted.
        step();
        step();
        check("rst pout", {22'd0, pout}, 0);
        check("rst ovf", {31'd0, ovf}, 0);
        check("rst busy", {31'd0, busy}, 0);
        check("rst valid", {31'd0, valid}, 0);
        sclr  = 1'b1;
        start = 1'b0;
        step();
        check("rst no_start busy", {31'd0, busy}, 0);
        check("rst no_start valid", {31'd0, valid}, 0);

        run_op("25x17", 25, 17, 425, 0, EARLY ? 5 : 10);
        step();
        step();
        check("25x17 pout_later", {22'd0, pout}, 425);

        run_op("1023x1023", 1023, 1023, 1, 1, 10);
        run_op("32x32", 32, 32, 0, 1, EARLY ? 6 : 10);
        run_op("1023x1", 1023, 1, 1023, 0, EARLY ? 1 : 10);

        // Start pulse during CALC must be ignored.
        pulse_at = EARLY ? 2 : 4;
        start = 1'b1;
        a_in  = 10'd7;
        b_in  = 10'd3;
        step();
        start = 1'b0;
        for (int i = 1; i < pulse_at; i++) begin
            check("7x3 busy_pre", {31'd0, busy}, 1);
            step();
        end
        check("7x3 busy_at_pulse", {31'd0, busy}, 1);
        start = 1'b1;
        a_in  = 10'd5;
        b_in  = 10'd5;
        step();
        start = 1'b0;
        wait_result("7x3", 21, 0, EARLY ? 2 : 10, pulse_at);
        check("7x3 no_restart busy", {31'd0, busy}, 0);

        run_op("5x5", 5, 5, 25, 0, EARLY ? 3 : 10);

        // Reset in the middle of an operation.
        rst_at = EARLY ? 3 : 5;
        start = 1'b1;
        a_in  = 10'd100;
        b_in  = 10'd9;
        step();
        start = 1'b0;
        for (int i = 1; i < rst_at; i++) begin
            step();
        end
        check("midrst busy_before", {31'd0, busy}, 1);
        sclr = 1'b0;
        step();
        sclr = 1'b1;
        check("midrst pout", {22'd0, pout}, 0);
        check("midrst ovf", {31'd0, ovf}, 0);
        check("midrst busy", {31'd0, busy}, 0);
        check("midrst valid", {31'd0, valid}, 0);
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (valid === 1'b1 || busy === 1'b1) vcount++;
        end
        check("midrst no_activity", vcount, 0);

        run_op("2x3", 2, 3, 6, 0, EARLY ? 2 : 10);
        run_op("100x3", 100, 3, 300, 0, EARLY ? 2 : 10);
        run_op("100x0", 100, 0, 0, 0, EARLY ? 1 : 10);
        run_op("1x512", 1, 512, 512, 0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
